// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter.
package axis_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      XFER = 2'd2
   } arb_state_e;

   // Index width for a source count; a single source still needs one bit.
   function automatic int srcWidth(input int nSrc);
      return (nSrc < 2) ? 1 : $clog2(nSrc);
   endfunction

endpackage

// File: rtl/axi_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after lastIdx, wrapping.
module rr_pick #(
   parameter int N_SRC = 4,
   parameter int SRC_W = 2
) (
   input  logic [N_SRC-1:0] req,
   input  logic [SRC_W-1:0] lastIdx,
   output logic [SRC_W-1:0] grantIdx,
   output logic             anyValid
);

   always_comb begin : pick
      logic [31:0] idx;
      grantIdx = '0;
      anyValid = 1'b0;
      idx      = '0;
      // Walk from farthest to nearest so the nearest requester wins the final assignment.
      for (int k = N_SRC; k >= 1; k--) begin
         idx = 32'((int'(lastIdx) + k) % N_SRC);
         if (req[idx[SRC_W-1:0]]) begin
            grantIdx = idx[SRC_W-1:0];
            anyValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_stream_arbiter.sv
// N-source AXI-Stream packet arbiter: round-robin grant locked per packet, registered output stage.
module axi_stream_arbiter
   import axis_arb_pkg::*;
#(
   parameter  int N_SRC     = 4,
   parameter  int DATA_W    = 16,
   parameter  int TUSER_W   = 1,
   parameter  int HAS_TLAST = 1,
   localparam int SRC_W     = srcWidth(N_SRC)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [N_SRC-1:0]         s_tValid,
   output logic [N_SRC-1:0]         s_tReady,
   input  logic [N_SRC*DATA_W-1:0]  s_tData,
   input  logic [N_SRC-1:0]         s_tLast,
   input  logic [N_SRC*TUSER_W-1:0] s_tUser,
   output logic                     m_tValid,
   input  logic                     m_tReady,
   output logic [DATA_W-1:0]        m_tData,
   output logic                     m_tLast,
   output logic [TUSER_W-1:0]       m_tUser,
   output logic [SRC_W-1:0]         m_tId,
   output arb_state_e               dbgState
);

   // Handshake: a beat moves when tValid and tReady are both 1 on a rising edge;
   // a source must hold its beat stable until accepted, the output stage holds likewise.

   arb_state_e        state;
   logic [SRC_W-1:0]  grant;
   logic [SRC_W-1:0]  lastGrant;
   logic [SRC_W-1:0]  pickIdx;
   logic              pickValid;
   logic              outFree;
   logic              beatAcc;
   logic              pktEnd;
   logic [DATA_W-1:0] selData;
   logic              selLast;
   logic [TUSER_W-1:0] selUser;

   rr_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) uPick (
      .req      (s_tValid),
      .lastIdx  (lastGrant),
      .grantIdx (pickIdx),
      .anyValid (pickValid)
   );

   assign selData = s_tData[int'(grant)*DATA_W +: DATA_W];
   assign selUser = s_tUser[int'(grant)*TUSER_W +: TUSER_W];
   assign selLast = s_tLast[grant];

   assign outFree = !m_tValid || m_tReady;
   assign beatAcc = (state == XFER) && s_tValid[grant] && outFree;
   assign pktEnd  = (HAS_TLAST == 0) || selLast;

   always_comb begin
      s_tReady = '0;
      if (state == XFER) s_tReady[grant] = outFree;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state     <= IDLE;
         grant     <= '0;
         lastGrant <= SRC_W'(N_SRC - 1);
      end else begin
         case (state)
            IDLE: if (|s_tValid) state <= ARB;
            ARB: begin
               if (pickValid) begin
                  grant <= pickIdx;
                  state <= XFER;
               end else begin
                  state <= IDLE;
               end
            end
            XFER: begin
               // A stalled source keeps the grant; only an accepted packet end releases it.
               if (beatAcc && pktEnd) begin
                  lastGrant <= grant;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_tValid <= 1'b0;
         m_tData  <= '0;
         m_tLast  <= 1'b0;
         m_tUser  <= '0;
         m_tId    <= '0;
      end else if (beatAcc) begin
         m_tValid <= 1'b1;
         m_tData  <= selData;
         m_tLast  <= (HAS_TLAST == 0) ? 1'b1 : selLast;
         m_tUser  <= selUser;
         m_tId    <= grant;
      end else if (m_tReady) begin
         m_tValid <= 1'b0;
      end
   end

   assign dbgState = state;

endmodule
